// File: rtl/param_sync_fifo_if.sv
// Producer/consumer bundle for param_sync_fifo: write and read ports, level
// programming, status flags and the sticky error flags with their clear.
interface param_sync_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W:0]   afull_lvl;
  logic [ADDR_W:0]   aempty_lvl;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;
  logic              clr_err;

  modport master (
    output flush, wr_en, wr_data, rd_en, afull_lvl, aempty_lvl, clr_err,
    input  rd_data, rd_valid, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, afull_lvl, aempty_lvl, clr_err,
    output rd_data, rd_valid, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with DEPTH = 2^ADDR_W entries, registered read port,
// programmable almost-full/almost-empty levels, synchronous flush and sticky errors.
module param_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  param_sync_fifo_if.slave     bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic [PTR_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              wr_acc;
  logic              rd_acc;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  always_comb begin
    count  = wptr_q - rptr_q;
    empty  = (wptr_q == rptr_q);
    full   = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
             (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
    wr_acc = bus.wr_en & ~full & ~bus.flush;
    rd_acc = bus.rd_en & ~empty & ~bus.flush;
  end

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PTR_W'(1);
      if (rd_acc) begin
        rptr_d     = rptr_q + PTR_W'(1);
        rd_data_d  = mem[rptr_q[ADDR_W-1:0]];
        rd_valid_d = 1'b1;
      end
      // A new error in the same cycle as clr_err keeps the flag set.
      if (bus.wr_en && full)       overflow_d = 1'b1;
      else if (bus.clr_err)        overflow_d = 1'b0;
      if (bus.rd_en && empty)      underflow_d = 1'b1;
      else if (bus.clr_err)        underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset; stale words are unreachable.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr_q[ADDR_W-1:0]] <= bus.wr_data;
  end

  assign bus.count        = count;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= bus.afull_lvl);
  assign bus.almost_empty = (count <= bus.aempty_lvl);
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo (DATA_W=8, DEPTH=16); read data is checked
// by a negedge monitor against a queue of expected words pushed at stimulus time.
module tb_param_sync_fifo;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] model_q[$];

  param_sync_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  param_sync_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one cycle of requests; words the FIFO should return are queued first.
  task automatic apply_stimulus(input logic w, input logic [7:0] d, input logic r,
                                input logic f, input logic c);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    bus.flush   = f;
    bus.clr_err = c;
    if (f) begin
      model_q.delete();
    end else begin
      if (r && model_q.size() != 0) exp_q.push_back(model_q.pop_front());
      if (w && model_q.size() + (r ? 1 : 0) <= 16 && !(model_q.size() == 16 && r == 1'b0))
        model_q.push_back(d);
    end
    @(posedge clk);
    #1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.flush   = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_rd_valid", 32'(bus.rd_data), 32'hFFFF_FFFF);
      end else begin
        check_output("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    bus.flush      = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_data    = '0;
    bus.rd_en      = 1'b0;
    bus.clr_err    = 1'b0;
    bus.afull_lvl  = 5'd0;
    bus.aempty_lvl = 5'd3;
    rst_n          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_count", 32'(bus.count), 32'd0);
    check_output("reset_empty", 32'(bus.empty), 32'd1);
    check_output("reset_full", 32'(bus.full), 32'd0);
    check_output("reset_rd_data", 32'(bus.rd_data), 32'd0);
    check_output("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    check_output("reset_overflow", 32'(bus.overflow), 32'd0);
    check_output("reset_underflow", 32'(bus.underflow), 32'd0);
    check_output("reset_almost_empty", 32'(bus.almost_empty), 32'd1);
    check_output("reset_almost_full_lvl0", 32'(bus.almost_full), 32'd1);
    bus.afull_lvl = 5'd12;
    #1;
    check_output("almost_full_lvl12_empty", 32'(bus.almost_full), 32'd0);
    rst_n = 1'b1;

    $display("[TB] fill 0x00..0x0F");
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      check_output("fill_count", 32'(bus.count), 32'(i + 1));
      if (i + 1 == 3)  check_output("almost_empty_at3", 32'(bus.almost_empty), 32'd1);
      if (i + 1 == 4)  check_output("almost_empty_at4", 32'(bus.almost_empty), 32'd0);
      if (i + 1 == 11) check_output("almost_full_at11", 32'(bus.almost_full), 32'd0);
      if (i + 1 == 12) check_output("almost_full_at12", 32'(bus.almost_full), 32'd1);
    end
    check_output("full_after_fill", 32'(bus.full), 32'd1);

    $display("[TB] overflow while full");
    apply_stimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    check_output("overflow_set", 32'(bus.overflow), 32'd1);
    check_output("overflow_count", 32'(bus.count), 32'd16);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_output("overflow_cleared", 32'(bus.overflow), 32'd0);

    $display("[TB] drain 16 words");
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check_output("drain_rd_valid", 32'(bus.rd_valid), 32'd1);
      check_output("drain_count", 32'(bus.count), 32'(15 - i));
      if (15 - i == 11) check_output("almost_full_deassert11", 32'(bus.almost_full), 32'd0);
    end
    check_output("empty_after_drain", 32'(bus.empty), 32'd1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_output("rd_valid_idle", 32'(bus.rd_valid), 32'd0);
    check_output("rd_data_hold", 32'(bus.rd_data), 32'h0F);

    $display("[TB] read+write while empty");
    apply_stimulus(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    check_output("underflow_set", 32'(bus.underflow), 32'd1);
    check_output("underflow_count", 32'(bus.count), 32'd1);
    check_output("underflow_rd_valid", 32'(bus.rd_valid), 32'd0);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check_output("read_0x55", 32'(bus.rd_data), 32'h55);
    check_output("underflow_cleared", 32'(bus.underflow), 32'd0);

    $display("[TB] steady read+write at count 8");
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1'b1, 8'(8'h20 + i), 1'b1, 1'b0, 1'b0);
      check_output("steady_count", 32'(bus.count), 32'd8);
    end

    $display("[TB] overflow then flush");
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    check_output("refill_full", 32'(bus.full), 32'd1);
    apply_stimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_output("pre_flush_count", 32'(bus.count), 32'd10);
    check_output("pre_flush_overflow", 32'(bus.overflow), 32'd1);
    apply_stimulus(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
    check_output("flush_count", 32'(bus.count), 32'd0);
    check_output("flush_empty", 32'(bus.empty), 32'd1);
    check_output("flush_overflow", 32'(bus.overflow), 32'd0);
    check_output("flush_rd_valid", 32'(bus.rd_valid), 32'd0);
    check_output("flush_rd_data_hold", 32'(bus.rd_data), 32'h45);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_output("post_flush_underflow", 32'(bus.underflow), 32'd1);
    apply_stimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    check_output("post_flush_count", 32'(bus.count), 32'd1);
    @(negedge clk);
    #1;
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_output("read_0x77_valid", 32'(bus.rd_valid), 32'd1);
    check_output("read_0x77_data", 32'(bus.rd_data), 32'h77);

    $display("[TB] asynchronous reset mid-stream");
    apply_stimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    #2;
    exp_q.delete();
    model_q.delete();
    rst_n = 1'b0;
    #1;
    check_output("async_count", 32'(bus.count), 32'd0);
    check_output("async_empty", 32'(bus.empty), 32'd1);
    check_output("async_full", 32'(bus.full), 32'd0);
    check_output("async_rd_valid", 32'(bus.rd_valid), 32'd0);
    check_output("async_rd_data", 32'(bus.rd_data), 32'd0);
    check_output("async_underflow", 32'(bus.underflow), 32'd0);
    check_output("async_overflow", 32'(bus.overflow), 32'd0);
    check_output("async_almost_empty", 32'(bus.almost_empty), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
